// File: rtl/led_pwm_sequencer_pkg.sv
// Shared constants for the LED PWM sequencer: mode encoding, FSM states and
// default sizing.
package led_pwm_sequencer_pkg;
    localparam int DEF_NUM_LEDS = 4;
    localparam int DEF_PWM_BITS = 4;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLINK,
        ST_CHASE,
        ST_BR_UP,
        ST_BR_DOWN
    } state_t;

    function automatic state_t entry_state(input logic [1:0] mode);
        case (mode)
            MODE_BLINK:   return ST_BLINK;
            MODE_CHASE:   return ST_CHASE;
            MODE_BREATHE: return ST_BR_UP;
            default:      return ST_IDLE;
        endcase
    endfunction
endpackage

// File: rtl/led_pwm_sequencer_if.sv
// Control/status bundle between the upstream tick stage and the sequencer.
interface led_pwm_sequencer_if #(
    parameter int NUM_LEDS = led_pwm_sequencer_pkg::DEF_NUM_LEDS,
    parameter int PWM_BITS = led_pwm_sequencer_pkg::DEF_PWM_BITS
);
    localparam int STEP_W = $clog2(NUM_LEDS);

    logic                io_tick;
    logic                io_enable;
    logic [1:0]          io_mode;
    logic [NUM_LEDS-1:0] io_leds;
    logic [STEP_W-1:0]   io_step;
    logic [PWM_BITS-1:0] io_duty;

    modport master (output io_tick, io_enable, io_mode,
                    input  io_leds, io_step, io_duty);
    modport slave  (input  io_tick, io_enable, io_mode,
                    output io_leds, io_step, io_duty);
endinterface

// File: rtl/led_pwm_sequencer_pwm_counter.sv
// Free-running PWM counter with a duty comparator; pwm_on is combinational
// and gets registered by the consumer.
module pwm_counter
    import led_pwm_sequencer_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);
    logic [PWM_BITS-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= r_cnt + PWM_BITS'(1);
    end

    assign pwm_on = (r_cnt < duty);
endmodule

// File: rtl/led_pwm_sequencer.sv
// Pattern sequencer: OFF / BLINK / CHASE / BREATHE driven by upstream ticks,
// with registered LED, step and duty outputs.
module led_pwm_sequencer
    import led_pwm_sequencer_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    led_pwm_sequencer_if.slave   bus
);
    localparam int                  STEP_W    = $clog2(NUM_LEDS);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_mode_q;
    logic                r_phase, w_phase_nxt;
    logic [STEP_W-1:0]   r_step, w_step_nxt;
    logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
    logic [NUM_LEDS-1:0] r_leds, w_leds_nxt;
    logic [STEP_W-1:0]   r_step_o;
    logic [PWM_BITS-1:0] r_duty_o;
    logic                w_pwm_on;
    logic                w_accept;

    pwm_counter #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clock  (clock),
        .reset  (reset),
        .duty   (r_duty),
        .pwm_on (w_pwm_on)
    );

    assign w_accept = bus.io_tick & bus.io_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode_q <= MODE_OFF;
            r_phase  <= 1'b0;
            r_step   <= '0;
            r_duty   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode_q <= bus.io_mode;
            r_phase  <= w_phase_nxt;
            r_step   <= w_step_nxt;
            r_duty   <= w_duty_nxt;
        end
    end

    // A mode change re-enters even while disabled so state never disagrees
    // with mode_q; it also swallows any coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_step_nxt  = r_step;
        w_duty_nxt  = r_duty;
        if (bus.io_mode != r_mode_q) begin
            w_state_nxt = entry_state(bus.io_mode);
            w_phase_nxt = 1'b0;
            w_step_nxt  = '0;
            w_duty_nxt  = '0;
        end else if (w_accept) begin
            case (r_state)
                ST_BLINK: w_phase_nxt = ~r_phase;
                ST_CHASE: w_step_nxt  = (r_step == STEP_LAST) ? '0 : r_step + STEP_W'(1);
                ST_BR_UP: begin
                    if (r_duty == DUTY_MAX) w_state_nxt = ST_BR_DOWN;
                    else                    w_duty_nxt  = r_duty + PWM_BITS'(1);
                end
                ST_BR_DOWN: begin
                    if (r_duty == '0) w_state_nxt = ST_BR_UP;
                    else              w_duty_nxt  = r_duty - PWM_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_leds_nxt = '0;
        if (bus.io_enable) begin
            case (r_state)
                ST_BLINK:              w_leds_nxt = {NUM_LEDS{r_phase}};
                ST_CHASE:              w_leds_nxt = NUM_LEDS'(1) << r_step;
                ST_BR_UP, ST_BR_DOWN:  w_leds_nxt = {NUM_LEDS{w_pwm_on}};
                default:               w_leds_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_leds   <= '0;
            r_step_o <= '0;
            r_duty_o <= '0;
        end else begin
            r_leds   <= w_leds_nxt;
            r_step_o <= r_step;
            r_duty_o <= r_duty;
        end
    end

    assign bus.io_leds = r_leds;
    assign bus.io_step = r_step_o;
    assign bus.io_duty = r_duty_o;
endmodule

// File: tb/tb_led_pwm_sequencer.sv
module tb_led_pwm_sequencer;
  import led_pwm_sequencer_pkg::*;

  localparam int K_LEDS = 0;
  localparam int K_STEP = 1;
  localparam int K_DUTY = 2;
  localparam int K_HI   = 3;

  typedef struct {
    int    due;
    int    kind;
    int    exp;
    string name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic [15:0] win;
  exp_t q[$];

  led_pwm_sequencer_if #(.NUM_LEDS(4), .PWM_BITS(4)) io ();

  led_pwm_sequencer #(.NUM_LEDS(4), .PWM_BITS(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    int   act;
    win = {win[14:0], (io.io_leds == 4'hF)};
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        K_LEDS:  act = int'(io.io_leds);
        K_STEP:  act = int'(io.io_step);
        K_DUTY:  act = int'(io.io_duty);
        default: act = $countones(win);
      endcase
      n_checks = n_checks + 1;
      if (e.due < cyc || act != e.exp) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %0d expected %0d (due %0d, cycle %0d)",
                 e.name, act, e.exp, e.due, cyc);
      end
    end
  end

  task automatic expect_at(input int due, input int kind, input int exp, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick_with(input logic [1:0] m);
    @(posedge clk); #1;
    io.io_mode = m;
    io.io_tick = 1'b1;
    @(posedge clk); #1;
    io.io_tick = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(posedge clk); #1;
    io.io_mode = m;
    @(posedge clk); #1;
  endtask

  task automatic set_enable(input logic en);
    @(posedge clk); #1;
    io.io_enable = en;
    @(posedge clk); #1;
  endtask

  int chase_leds [5] = '{1, 2, 4, 8, 1};
  int chase_step [5] = '{0, 1, 2, 3, 0};
  int blink_leds [3] = '{15, 0, 15};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    win      = '0;
    rst          = 1'b1;
    io.io_tick   = 1'b0;
    io.io_enable = 1'b1;
    io.io_mode   = MODE_OFF;

    @(posedge clk); #1;
    expect_at(cyc, K_LEDS, 0, "reset_leds");
    expect_at(cyc, K_STEP, 0, "reset_step");
    expect_at(cyc, K_DUTY, 0, "reset_duty");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (io.io_leds !== 4'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL idle_leds: got %0d expected 0", io.io_leds);
    end

    tick_with(MODE_CHASE);
    expect_at(cyc + 1, K_LEDS, chase_leds[0], "chase_leds_0");
    expect_at(cyc + 1, K_STEP, chase_step[0], "chase_step_0");
    for (int k = 1; k < 5; k++) begin
      repeat (48) @(posedge clk);
      tick_with(MODE_CHASE);
      expect_at(cyc + 1, K_LEDS, chase_leds[k], $sformatf("chase_leds_%0d", k));
      expect_at(cyc + 1, K_STEP, chase_step[k], $sformatf("chase_step_%0d", k));
    end

    tick_with(MODE_CHASE);
    expect_at(cyc + 1, K_LEDS, 2, "pre_coll_leds_a");
    tick_with(MODE_CHASE);
    expect_at(cyc + 1, K_LEDS, 4, "pre_coll_leds_b");
    expect_at(cyc + 1, K_STEP, 2, "pre_coll_step");
    tick_with(MODE_BLINK);
    expect_at(cyc + 1, K_LEDS, 0, "coll_leds");
    expect_at(cyc + 1, K_STEP, 0, "coll_step");

    for (int k = 0; k < 3; k++) begin
      repeat (3) @(posedge clk);
      tick_with(MODE_BLINK);
      expect_at(cyc + 1, K_LEDS, blink_leds[k], $sformatf("blink_leds_%0d", k));
    end

    set_mode(MODE_CHASE);
    expect_at(cyc + 1, K_LEDS, 1, "gate_entry_leds");
    tick_with(MODE_CHASE);
    expect_at(cyc + 1, K_LEDS, 2, "gate_step1_leds");
    expect_at(cyc + 1, K_STEP, 1, "gate_step1_step");
    repeat (2) @(posedge clk);
    set_enable(1'b0);
    expect_at(cyc, K_LEDS, 0, "gate_off_leds");
    for (int k = 0; k < 3; k++) begin
      tick_with(MODE_CHASE);
      expect_at(cyc + 1, K_LEDS, 0, $sformatf("gate_dis_leds_%0d", k));
      expect_at(cyc + 1, K_STEP, 1, $sformatf("gate_dis_step_%0d", k));
    end
    repeat (2) @(posedge clk);
    set_enable(1'b1);
    expect_at(cyc, K_LEDS, 2, "gate_resume_leds");
    expect_at(cyc, K_STEP, 1, "gate_resume_step");

    set_mode(MODE_BREATHE);
    expect_at(cyc + 1, K_DUTY, 0, "br_entry_duty");
    for (int k = 1; k <= 15; k++) begin
      tick_with(MODE_BREATHE);
      expect_at(cyc + 1, K_DUTY, k, $sformatf("br_up_%0d", k));
    end
    repeat (20) @(posedge clk);
    #1 expect_at(cyc, K_HI, 15, "br_duty15_on_of_16");
    n_checks = n_checks + 1;
    if (io.io_duty !== 4'd15) begin
      n_fail = n_fail + 1;
      $display("FAIL br_duty15_direct: got %0d expected 15", io.io_duty);
    end
    tick_with(MODE_BREATHE);
    expect_at(cyc + 1, K_DUTY, 15, "br_turn_hold");
    for (int k = 14; k >= 9; k--) begin
      tick_with(MODE_BREATHE);
      expect_at(cyc + 1, K_DUTY, k, $sformatf("br_down_%0d", k));
    end
    repeat (4) @(posedge clk);

    @(posedge clk); #2;
    rst = 1'b1;
    expect_at(cyc, K_LEDS, 0, "async_rst_leds");
    expect_at(cyc, K_STEP, 0, "async_rst_step");
    expect_at(cyc, K_DUTY, 0, "async_rst_duty");
    #1;
    n_checks = n_checks + 1;
    if (io.io_leds !== 4'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL async_rst_leds_direct: got %0d expected 0", io.io_leds);
    end
    n_checks = n_checks + 1;
    if (io.io_step !== 2'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL async_rst_step_direct: got %0d expected 0", io.io_step);
    end
    n_checks = n_checks + 1;
    if (io.io_duty !== 4'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL async_rst_duty_direct: got %0d expected 0", io.io_duty);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick_with(MODE_BREATHE);
    expect_at(cyc + 1, K_DUTY, 1, "post_rst_reentry_duty");

    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL %s: never compared, expected %0d", e.name, e.exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pwm_sequencer.md
LED_PWM_SEQUENCER -- requirements
Module: led_pwm_sequencer

Interface
REQ-001 Parameter NUM_LEDS, default 4, number of driven LEDs (range 2..16).
REQ-002 Parameter PWM_BITS, default 4, width of the PWM counter and the duty register.
REQ-003 clock  input  1  single clock domain; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_tick  input  1  one-cycle pulse from the upstream period/blink stage; this is the step event.
REQ-006 io_enable  input  1  high = sequencing active; low = outputs dark and state frozen.
REQ-007 io_mode  input  2  pattern select: 0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE.
REQ-008 io_leds  output  NUM_LEDS  registered LED drive, bit i drives LED i.
REQ-009 io_step  output  clog2(NUM_LEDS)  current chase index, registered.
REQ-010 io_duty  output  PWM_BITS  current breathe duty, registered.

Function
REQ-011 pwm_cnt shall be free-running, incrementing every cycle and wrapping from 2^PWM_BITS-1 to 0, independent of io_enable.
REQ-012 The FSM shall have the states IDLE, BLINK, CHASE, BR_UP and BR_DOWN.
REQ-013 The FSM shall register io_mode into mode_q every cycle.
  - When io_mode != mode_q, the next state shall be the entry state of io_mode: OFF->IDLE, BLINK->BLINK, CHASE->CHASE, BREATHE->BR_UP.
  - On that same transition, phase, step and duty shall clear to 0.
REQ-014 A mode change shall take priority over a coincident io_tick; that tick shall be dropped.
REQ-015 IDLE: io_leds = 0, and ticks shall be ignored.
REQ-016 BLINK: each accepted tick shall toggle phase, and io_leds shall equal all bits = phase.
REQ-017 CHASE: each accepted tick shall advance step by +1, wrapping from NUM_LEDS-1 to 0, and io_leds shall equal one-hot(step).
REQ-018 BR_UP: each accepted tick shall increment duty.
  - When duty == 2^PWM_BITS-1 and a tick arrives, duty shall hold and the state shall go to BR_DOWN.
REQ-019 BR_DOWN: each accepted tick shall decrement duty.
  - When duty == 0 and a tick arrives, duty shall hold and the state shall go to BR_UP.
REQ-020 In BR_UP and BR_DOWN, every bit of io_leds shall equal (pwm_cnt < duty).
  - duty 0 gives always off; duty max gives on for (2^PWM_BITS-1) of every 2^PWM_BITS cycles.
REQ-021 io_enable low shall behave as follows:
  - ticks are not accepted;
  - state, phase, step and duty hold;
  - io_leds = 0 from the next cycle.
  Re-enabling shall resume from the held values.
REQ-022 io_leds, io_step and io_duty shall be registered.
  - They reflect state one cycle after the edge that updated it.
  - io_tick to visible LED change takes 2 cycles.
REQ-023 A tick asserted for multiple consecutive cycles shall count once per cycle high (no edge detection).

Reset
REQ-024 While reset is high, asynchronously:
  - state = IDLE;
  - mode_q = OFF;
  - phase, step, duty and pwm_cnt = 0;
  - io_leds, io_step and io_duty = 0.
REQ-025 Reset asserted mid-pattern shall abandon the pattern; after release, the block shall re-enter per io_mode through the REQ-013 mismatch rule on the first clock.

Structure
REQ-026 A shared package shall hold:
  - the mode encoding constants (OFF/BLINK/CHASE/BREATHE);
  - the FSM state enumeration;
  - the default NUM_LEDS and PWM_BITS.
REQ-027 The free-running counter and comparator shall be one sub-module, pwm_counter (parameter PWM_BITS; inputs clock, reset, duty; output pwm_on).
REQ-028 The FSM and the output registers shall reside in led_pwm_sequencer.

Verification (NUM_LEDS=4, PWM_BITS=4)
REQ-029 Chase wrap: with mode=CHASE and enable=1, apply 5 ticks spaced 50 cycles apart -> io_leds = 0001, 0010, 0100, 1000, 0001, each two cycles after its tick.
REQ-030 Blink: with mode=BLINK, apply 3 ticks -> io_leds = 1111, 0000, 1111.
REQ-031 Breathe turnaround: with mode=BREATHE, apply 16 ticks -> io_duty reaches 15, and the 16th tick flips to BR_DOWN with duty held at 15; the next tick gives duty 14; with duty=15, io_leds is high for 15 of 16 cycles.
REQ-032 Mode/tick collision: in CHASE with step=2, switch mode to BLINK in the same cycle as a tick -> step clears to 0, phase = 0, and io_leds = 0000.
REQ-033 Enable gating: in CHASE with step=1, drop enable and apply 3 ticks, then raise enable -> io_leds = 0000 while disabled, then 0010.
REQ-034 Async reset: assert reset mid-BREATHE at duty=9, between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
